// File: rtl/uart_mem_master.sv
// UART memory-link initiator: sends one 32-bit read/write request as 8N1 bytes on Tx and
// collects the responder's reply on Rx. Define UART_MEM_TIMEOUT_EN to add a response watchdog.
module uart_mem_master #(
    parameter int CLKS_PER_BIT   = 868,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic        Tx,
    input  logic        Rx
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP, DONE} state_t;
    state_t state, state_nx;

    logic          we_q;
    logic [31:0]   addr_q, wdata_q;
    logic [9:0]    tx_sh;
    logic [CW-1:0] tx_cnt;
    logic [3:0]    tx_bit, tx_byte;
    logic [7:0]    next_byte;
    logic          bit_end, frame_end;

    logic          rx_s1, rx_s2, rx_d, rx_active, rx_done, rx_ferr, rx_flush;
    logic [3:0]    rx_bit;
    logic [CW-1:0] rx_cnt;
    logic [7:0]    rx_sh;

    logic [1:0]    resp_cnt;
    logic [23:0]   acc;
    logic          err_q, set_err, wd_hit;

`ifdef UART_MEM_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    logic [WW-1:0] wd_cnt;

    // Watchdog restarts on entry to WAIT_RESP and after every received byte.
    always_ff @(posedge CLK) begin
        if (RST || state != WAIT_RESP || rx_done) wd_cnt <= '0;
        else                                      wd_cnt <= wd_cnt + WW'(1);
    end
    assign wd_hit = (state == WAIT_RESP) && (wd_cnt == WW'(TIMEOUT_CYCLES - 1));
`else
    assign wd_hit = 1'b0;
`endif
    assign rx_flush = wd_hit;

    assign req_ready  = (state == IDLE) && !RST;
    assign busy       = (state != IDLE);
    assign resp_valid = (state == DONE);
    assign resp_err   = resp_valid && err_q;
    assign Tx         = (state == SEND) ? tx_sh[0] : 1'b1;

    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_nx  = state;
        next_byte = 8'h00;
        bit_end   = (tx_cnt == BIT_LAST);
        frame_end = bit_end && (tx_bit == 4'd9) && (tx_byte == (we_q ? 4'd8 : 4'd4));
        set_err   = wd_hit || (rx_done && (rx_ferr || (we_q && rx_sh != 8'h06)));
        case (tx_byte + 4'd1)
            4'd1:    next_byte = addr_q[31:24];
            4'd2:    next_byte = addr_q[23:16];
            4'd3:    next_byte = addr_q[15:8];
            4'd4:    next_byte = addr_q[7:0];
            4'd5:    next_byte = wdata_q[31:24];
            4'd6:    next_byte = wdata_q[23:16];
            4'd7:    next_byte = wdata_q[15:8];
            4'd8:    next_byte = wdata_q[7:0];
            default: next_byte = 8'h00;
        endcase
        case (state)
            IDLE:      if (req_valid) state_nx = SEND;
            SEND:      if (frame_end) state_nx = WAIT_RESP;
            WAIT_RESP: if (set_err || (rx_done && (we_q || resp_cnt == 2'd3))) state_nx = DONE;
            default:   state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tx_sh      <= '1;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_byte    <= '0;
            resp_cnt   <= '0;
            acc        <= '0;
            err_q      <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (req_valid) begin
                    we_q     <= req_we;
                    addr_q   <= req_addr;
                    wdata_q  <= req_wdata;
                    tx_sh    <= {1'b1, (req_we ? 8'h57 : 8'h52), 1'b0};
                    tx_cnt   <= '0;
                    tx_bit   <= '0;
                    tx_byte  <= '0;
                    resp_cnt <= '0;
                    err_q    <= 1'b0;
                end
                SEND: if (bit_end) begin
                    tx_cnt <= '0;
                    if (tx_bit == 4'd9) begin
                        tx_bit  <= '0;
                        tx_byte <= tx_byte + 4'd1;
                        tx_sh   <= {1'b1, next_byte, 1'b0};
                    end else begin
                        tx_bit <= tx_bit + 4'd1;
                        tx_sh  <= {1'b1, tx_sh[9:1]};
                    end
                end else begin
                    tx_cnt <= tx_cnt + CNT_ONE;
                end
                WAIT_RESP: begin
                    if (set_err) err_q <= 1'b1;
                    // Read data is committed only when the fourth good byte lands.
                    if (rx_done && !rx_ferr && !we_q) begin
                        acc      <= {acc[15:0], rx_sh};
                        resp_cnt <= resp_cnt + 2'd1;
                        if (resp_cnt == 2'd3) resp_rdata <= {acc, rx_sh};
                    end
                end
                default: ;
            endcase
        end
    end

    // Receiver: start re-checked at mid-bit, then data and stop sampled one bit period apart.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_d      <= 1'b1;
            rx_active <= 1'b0;
            rx_bit    <= '0;
            rx_cnt    <= '0;
            rx_sh     <= '0;
            rx_done   <= 1'b0;
            rx_ferr   <= 1'b0;
        end else begin
            rx_s1   <= Rx;
            rx_s2   <= rx_s1;
            rx_d    <= rx_s2;
            rx_done <= 1'b0;
            if (rx_flush) begin
                rx_active <= 1'b0;
                rx_bit    <= '0;
                rx_cnt    <= '0;
            end else if (!rx_active) begin
                if (!rx_s2 && rx_d) begin
                    rx_active <= 1'b1;
                    rx_bit    <= '0;
                    rx_cnt    <= '0;
                end
            end else if (rx_bit == 4'd0) begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt <= '0;
                    if (rx_s2) rx_active <= 1'b0;
                    else       rx_bit    <= 4'd1;
                end else begin
                    rx_cnt <= rx_cnt + CNT_ONE;
                end
            end else if (rx_cnt == BIT_LAST) begin
                rx_cnt <= '0;
                if (rx_bit == 4'd9) begin
                    rx_active <= 1'b0;
                    rx_done   <= 1'b1;
                    rx_ferr   <= !rx_s2;
                end else begin
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_bit <= rx_bit + 4'd1;
                end
            end else begin
                rx_cnt <= rx_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_uart_mem_master.sv
// Directed bench for uart_mem_master with CLKS_PER_BIT=4; acts as the remote responder on Rx.
module tb_uart_mem_master;

    localparam int CPB = 4;
    localparam int TMO = 200;

    logic        CLK = 1'b0;
    logic        RST, req_valid, req_we, Rx;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err, busy, Tx;
    logic [31:0] resp_rdata;

    int vectors = 0;
    int miscompares = 0;
    int accept_cnt = 0;

    always #5 CLK = ~CLK;

    uart_mem_master #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy), .Tx(Tx), .Rx(Rx)
    );

    always @(posedge CLK) if (!RST && req_valid && req_ready) accept_cnt++;

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation still running, want finished");
        $fatal(1);
    end

    // Issue a request, then check every Tx cycle of the frame against the expected 8N1 bytes.
    task automatic send_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input bit hold, input bit wiggle);
        logic [7:0] exp_b [9];
        logic       exp_bit;
        int nb, bad_tx, bad_hs, w, k, j;
        exp_b[0] = we ? 8'h57 : 8'h52;
        exp_b[1] = addr[31:24];  exp_b[2] = addr[23:16];  exp_b[3] = addr[15:8];  exp_b[4] = addr[7:0];
        exp_b[5] = wdata[31:24]; exp_b[6] = wdata[23:16]; exp_b[7] = wdata[15:8]; exp_b[8] = wdata[7:0];
        nb = we ? 9 : 5;
        w = 0;
        @(negedge CLK);
        while (req_ready !== 1'b1 && w < 100) begin @(negedge CLK); w++; end
        vectors++;
        if (req_ready !== 1'b1 || Tx !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_before_req: req_ready=%b Tx=%b, want 1 1", req_ready, Tx);
        end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        @(posedge CLK); #1;
        if (!hold) begin
            req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
        end
        bad_tx = 0; bad_hs = 0;
        for (int i = 0; i < nb * 10 * CPB; i++) begin
            @(negedge CLK);
            k = i / (10 * CPB);
            j = (i / CPB) % 10;
            exp_bit = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : exp_b[k][j-1];
            if (Tx !== exp_bit) bad_tx++;
            if (req_ready !== 1'b0 || busy !== 1'b1) bad_hs++;
            if (wiggle && i == 50) req_addr = ~addr;
        end
        vectors++;
        if (bad_tx != 0) begin
            miscompares++;
            $display("FAIL tx_frame: %0d wrong Tx cycles, want 0 (we=%b addr=%h)", bad_tx, we, addr);
        end
        vectors++;
        if (bad_hs != 0) begin
            miscompares++;
            $display("FAIL send_ready_busy: %0d cycles with req_ready!=0 or busy!=1, want 0", bad_hs);
        end
    endtask

    task automatic rx_byte(input logic [7:0] b, input logic stop);
        for (int j = 0; j < 10; j++) begin
            Rx = (j == 0) ? 1'b0 : (j == 9) ? stop : b[j-1];
            repeat (CPB) @(posedge CLK);
            #1;
        end
        Rx = 1'b1;
    endtask

    task automatic wait_resp(input string name, input logic exp_err, input logic chk_data,
                             input logic [31:0] exp_data);
        int n = 0;
        do begin @(negedge CLK); n++; end while (resp_valid !== 1'b1 && n < 600);
        req_valid = 1'b0;
        vectors++;
        if (resp_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_resp_valid: no resp_valid within 600 cycles, want pulse", name);
            return;
        end
        vectors++;
        if (resp_err !== exp_err) begin
            miscompares++;
            $display("FAIL %s_resp_err: got %b want %b", name, resp_err, exp_err);
        end
        if (chk_data) begin
            vectors++;
            if (resp_rdata !== exp_data) begin
                miscompares++;
                $display("FAIL %s_rdata: got %h want %h", name, resp_rdata, exp_data);
            end
        end
        vectors++;
        if (req_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_done_state: req_ready=%b busy=%b, want 0 1", name, req_ready, busy);
        end
        @(negedge CLK);
        vectors++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_after_done: resp_valid=%b req_ready=%b busy=%b, want 0 1 0",
                     name, resp_valid, req_ready, busy);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; Rx = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        vectors++;
        if (Tx !== 1'b1 || req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_err !== 1'b0 ||
            busy !== 1'b0 || resp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_state: Tx=%b rdy=%b rv=%b re=%b busy=%b rdata=%h, want 1 0 0 0 0 0",
                     Tx, req_ready, resp_valid, resp_err, busy, resp_rdata);
        end
        RST = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_reset: got %b want 1", req_ready);
        end
    endtask

    task automatic test_read();
        send_req(1'b0, 32'h0000_1234, 32'h0, 1'b0, 1'b0);
        @(posedge CLK); #1;
        rx_byte(8'hDE, 1'b1); rx_byte(8'hAD, 1'b1); rx_byte(8'hBE, 1'b1); rx_byte(8'hEF, 1'b1);
        wait_resp("read", 1'b0, 1'b1, 32'hDEAD_BEEF);
    endtask

    task automatic test_write_ack();
        send_req(1'b1, 32'h0000_0010, 32'hA5A5_0F0F, 1'b0, 1'b0);
        @(posedge CLK); #1;
        rx_byte(8'h06, 1'b1);
        wait_resp("write_ack", 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_write_nak();
        send_req(1'b1, 32'h0000_0010, 32'hA5A5_0F0F, 1'b0, 1'b0);
        @(posedge CLK); #1;
        rx_byte(8'h15, 1'b1);
        wait_resp("write_nak", 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_handshake();
        int a0 = accept_cnt;
        send_req(1'b0, 32'h00AB_CDEF, 32'h0, 1'b1, 1'b1);
        @(posedge CLK); #1;
        rx_byte(8'h11, 1'b1); rx_byte(8'h22, 1'b1); rx_byte(8'h33, 1'b1); rx_byte(8'h44, 1'b1);
        wait_resp("held_valid", 1'b0, 1'b1, 32'h1122_3344);
        repeat (3) @(negedge CLK);
        vectors++;
        if (accept_cnt - a0 != 1) begin
            miscompares++;
            $display("FAIL accept_count: got %0d want 1", accept_cnt - a0);
        end
        req_addr = '0;
    endtask

    task automatic test_glitch();
        send_req(1'b0, 32'h0000_0055, 32'h0, 1'b0, 1'b0);
        @(posedge CLK); #1;
        Rx = 1'b0;
        @(posedge CLK); #1;
        Rx = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        rx_byte(8'h0F, 1'b1); rx_byte(8'h1E, 1'b1); rx_byte(8'h2D, 1'b1); rx_byte(8'h3C, 1'b1);
        wait_resp("glitch", 1'b0, 1'b1, 32'h0F1E_2D3C);
    endtask

    task automatic test_framing();
        send_req(1'b0, 32'h0000_0066, 32'h0, 1'b0, 1'b0);
        @(posedge CLK); #1;
        rx_byte(8'hDE, 1'b0);
        wait_resp("framing", 1'b1, 1'b1, 32'h0F1E_2D3C);
    endtask

    task automatic test_reset_mid_send();
        int seen = 0;
        @(negedge CLK);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0077;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        repeat (2 * 10 * CPB + 7) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        vectors++;
        if (Tx !== 1'b1 || busy !== 1'b0 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_send_reset: Tx=%b busy=%b rdy=%b rv=%b, want 1 0 0 0",
                     Tx, busy, req_ready, resp_valid);
        end
        RST = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_abort: got %b want 1", req_ready);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (resp_valid === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL abort_no_resp: %0d resp_valid cycles, want 0", seen);
        end
        send_req(1'b0, 32'h2468_ACE0, 32'h0, 1'b0, 1'b0);
        @(posedge CLK); #1;
        rx_byte(8'hCA, 1'b1); rx_byte(8'hFE, 1'b1); rx_byte(8'hBA, 1'b1); rx_byte(8'hBE, 1'b1);
        wait_resp("read_after_abort", 1'b0, 1'b1, 32'hCAFE_BABE);
    endtask

    task automatic test_no_responder();
        int cyc = 0;
        send_req(1'b0, 32'h0000_0099, 32'h0, 1'b0, 1'b0);
`ifdef UART_MEM_TIMEOUT_EN
        @(posedge CLK);
        while (cyc < 400) begin
            @(posedge CLK); cyc++; #1;
            if (resp_valid === 1'b1) break;
        end
        vectors++;
        if (cyc != TMO || resp_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout: resp after %0d cycles err=%b, want %0d cycles err=1",
                     cyc, resp_err, TMO);
        end
`else
        for (int i = 0; i < 10000; i++) begin
            @(negedge CLK);
            if (busy !== 1'b1 || resp_valid !== 1'b0) cyc++;
        end
        vectors++;
        if (cyc != 0) begin
            miscompares++;
            $display("FAIL silent_responder: %0d cycles not busy or with resp_valid, want 0", cyc);
        end
`endif
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        vectors++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL recover_reset: busy=%b rdy=%b, want 0 1", busy, req_ready);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_ack();
        test_write_nak();
        test_handshake();
        test_glitch();
        test_framing();
        test_reset_mid_send();
        test_no_responder();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
